// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b - bin), LSB first, valid/ready on both sides.
// Optional NZCV flag generation is enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;

    logic w_d;
    logic w_brw_next;
    logic w_last;
    logic w_accept;
    logic w_busy;

    always_comb begin
        w_d        = r_a[0] ^ r_b[0] ^ r_brw;
        w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
        w_last     = (r_cnt == LAST);
        w_busy     = (r_state == S_BUSY);
        w_accept   = (r_state == S_IDLE) && in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at diff[0].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_diff <= '0;
            r_brw  <= bin;
            r_cnt  <= '0;
        end else if (w_busy) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_brw  <= w_brw_next;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign diff = r_diff;
    assign bout = r_brw;

`ifdef SERIAL_SUB_FLAGS_EN
    logic r_any;
    logic r_fn;
    logic r_fz;
    logic r_fc;
    logic r_fv;

    // On the last BUSY cycle r_a[0]/r_b[0] are the operand MSBs and w_d is the result MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any <= 1'b0;
            r_fn  <= 1'b0;
            r_fz  <= 1'b0;
            r_fc  <= 1'b0;
            r_fv  <= 1'b0;
        end else if (w_accept) begin
            r_any <= 1'b0;
        end else if (w_busy) begin
            r_any <= r_any | w_d;
            if (w_last) begin
                r_fn <= w_d;
                r_fz <= ~(r_any | w_d);
                r_fc <= ~w_brw_next;
                r_fv <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
            end
        end
    end

    assign flag_n = r_fn;
    assign flag_z = r_fz;
    assign flag_c = r_fc;
    assign flag_v = r_fv;
`else
    assign flag_n = 1'b0;
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule
